// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared pipeline definitions: controller state encoding, NOP encoding, x0 index.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipeline_pkg;

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      LOAD_STALL = 2'd1,
      HALT       = 2'd2
   } state_t;

   // addi x0, x0, 0 -- what a flushed pipeline register carries
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   localparam logic [4:0]  REG_ZERO  = 5'd0;

   // A source operand conflicts with rd only if the instruction actually reads it
   function automatic logic src_match(input logic use_src,
                                      input logic [4:0] src,
                                      input logic [4:0] rd);
      return use_src && (src == rd);
   endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between pipeline datapath (master) and the sequencer (slave).
// Latency: n/a (wires only).
// Backpressure: dmem_busy freezes the pipeline through the enables carried here.
interface pipeline_hazard_ctrl_if #(
   parameter int CNT_W = 32
);
   logic [4:0]       rs1_ID;
   logic [4:0]       rs2_ID;
   logic             use_rs1_ID;
   logic             use_rs2_ID;
   logic [4:0]       rd_EX;
   logic             mem_read_EX;
   logic             branch_taken_EX;
   logic             halt_EX;
   logic             dmem_busy;
   logic             pc_en;
   logic             if_id_en;
   logic             if_id_flush;
   logic             id_ex_en;
   logic             id_ex_flush;
   logic             ex_mem_en;
   logic             nop_EX;
   logic             halted;
   logic [CNT_W-1:0] stall_cycles;
   logic [CNT_W-1:0] flush_count;

   modport slave (
      input  rs1_ID, rs2_ID, use_rs1_ID, use_rs2_ID, rd_EX, mem_read_EX,
             branch_taken_EX, halt_EX, dmem_busy,
      output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en,
             nop_EX, halted, stall_cycles, flush_count
   );

   modport master (
      output rs1_ID, rs2_ID, use_rs1_ID, use_rs2_ID, rd_EX, mem_read_EX,
             branch_taken_EX, halt_EX, dmem_busy,
      input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en,
             nop_EX, halted, stall_cycles, flush_count
   );

endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
// Latency: count reflects inc one cycle later.
// Backpressure: none; inc is ignored once saturated.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] r_count;

   // Clear has priority; increments stop at the all-ones value
   always_ff @(posedge clk) begin
      if (clr) begin
         r_count <= '0;
      end else if (inc && (r_count != {W{1'b1}})) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign count = r_count;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32 pipeline (load-use, branch, dmem freeze, halt).
// Latency: enables/flushes combinational in the hazard cycle; nop_EX, halted, counters registered.
// Backpressure: dmem_busy drops every enable and holds all controller state.
module pipeline_hazard_ctrl
   import pipeline_pkg::*;
#(
   parameter int LOAD_STALL_CYCLES = 2,
   parameter int CNT_W             = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   pipeline_hazard_ctrl_if.slave hz
);

   // Bubbles still owed after the first one, which is issued from RUN
   localparam logic [2:0] STALL_RELOAD = 3'(LOAD_STALL_CYCLES - 1);

   state_t     r_state;
   state_t     w_state_nxt;
   logic [2:0] r_cnt;
   logic [2:0] w_cnt_nxt;
   logic       r_nop_ex;
   logic       r_halted;

   logic       w_qual;
   logic       w_lu;
   logic       w_stall_inc;
   logic       w_flush_inc;
   logic       w_pc_en;
   logic       w_if_id_en;
   logic       w_if_id_flush;
   logic       w_id_ex_en;
   logic       w_id_ex_flush;
   logic       w_ex_mem_en;

   // A bubble in EX must never trigger a branch, halt or load-use action
   assign w_qual = !r_nop_ex;
   assign w_lu   = w_qual && hz.mem_read_EX && (hz.rd_EX != REG_ZERO) &&
                   (src_match(hz.use_rs1_ID, hz.rs1_ID, hz.rd_EX) ||
                    src_match(hz.use_rs2_ID, hz.rs2_ID, hz.rd_EX));

   // Prioritised hazard resolution: reset, freeze, halt, branch, load-use
   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_stall_inc   = 1'b0;
      w_flush_inc   = 1'b0;
      w_pc_en       = 1'b1;
      w_if_id_en    = 1'b1;
      w_if_id_flush = 1'b0;
      w_id_ex_en    = 1'b1;
      w_id_ex_flush = 1'b0;
      w_ex_mem_en   = 1'b1;

      if (rst) begin
         // Clock NOPs into every stage while reset is held
         w_if_id_flush = 1'b1;
         w_id_ex_flush = 1'b1;
      end else if (hz.dmem_busy) begin
         w_pc_en     = 1'b0;
         w_if_id_en  = 1'b0;
         w_id_ex_en  = 1'b0;
         w_ex_mem_en = 1'b0;
         w_stall_inc = (r_state != HALT);
      end else begin
         unique case (r_state)
            RUN: begin
               if (w_qual && hz.halt_EX) begin
                  w_pc_en       = 1'b0;
                  w_if_id_flush = 1'b1;
                  w_id_ex_flush = 1'b1;
                  w_state_nxt   = HALT;
               end else if (w_qual && hz.branch_taken_EX) begin
                  // ID holds a wrong-path instruction, so this wins over load-use
                  w_if_id_flush = 1'b1;
                  w_id_ex_flush = 1'b1;
                  w_flush_inc   = 1'b1;
               end else if (w_lu) begin
                  w_pc_en       = 1'b0;
                  w_if_id_en    = 1'b0;
                  w_id_ex_flush = 1'b1;
                  w_stall_inc   = 1'b1;
                  if (LOAD_STALL_CYCLES > 1) begin
                     w_cnt_nxt   = STALL_RELOAD;
                     w_state_nxt = LOAD_STALL;
                  end
               end
            end
            LOAD_STALL: begin
               // EX holds a bubble here, so no fresh load-use can arise
               w_pc_en       = 1'b0;
               w_if_id_en    = 1'b0;
               w_id_ex_flush = 1'b1;
               w_stall_inc   = 1'b1;
               w_cnt_nxt     = r_cnt - 3'd1;
               if (r_cnt == 3'd1) begin
                  w_state_nxt = RUN;
               end
            end
            HALT: begin
               w_pc_en       = 1'b0;
               w_if_id_flush = 1'b1;
               w_id_ex_flush = 1'b1;
            end
            default: begin
               w_state_nxt = RUN;
            end
         endcase
      end
   end

   // Controller state; nop_EX tracks what ID/EX actually captured
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= RUN;
         r_cnt    <= 3'd0;
         r_nop_ex <= 1'b1;
         r_halted <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_halted <= (w_state_nxt == HALT);
         if (w_id_ex_en) begin
            r_nop_ex <= w_id_ex_flush;
         end
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .clr   (rst),
      .inc   (w_stall_inc),
      .count (hz.stall_cycles)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .clr   (rst),
      .inc   (w_flush_inc),
      .count (hz.flush_count)
   );

   assign hz.pc_en       = w_pc_en;
   assign hz.if_id_en    = w_if_id_en;
   assign hz.if_id_flush = w_if_id_flush;
   assign hz.id_ex_en    = w_id_ex_en;
   assign hz.id_ex_flush = w_id_ex_flush;
   assign hz.ex_mem_en   = w_ex_mem_en;
   assign hz.nop_EX      = r_nop_ex;
   assign hz.halted      = r_halted;

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RV32 pipeline.
- Detects load-use hazards and inserts a programmable number of bubbles. Flushes wrong-path instructions on a taken branch. Freezes the whole pipeline while data memory is busy. Parks the core on halt.
- Drives the pipeline-register enables/flushes and the registered nop_EX flag that the EX-stage forwarding logic consumes.
- Also keeps saturating stall and flush performance counters.

Parameters:
- LOAD_STALL_CYCLES, 2, bubbles inserted per load-use hazard. Valid range 1..7. The default of 2 is required because load results are never forwarded; the consumer waits for register-file write-through.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- rs1_ID  in  5  source register 1 of the instruction in ID
- rs2_ID  in  5  source register 2 of the instruction in ID
- use_rs1_ID  in  1  ID instruction reads rs1
- use_rs2_ID  in  1  ID instruction reads rs2
- rd_EX  in  5  destination register of the instruction in EX
- mem_read_EX  in  1  instruction in EX is a load
- branch_taken_EX  in  1  branch/jump resolved taken in EX
- halt_EX  in  1  ecall/ebreak in EX
- dmem_busy  in  1  data memory has not completed its access this cycle
- pc_en  out  1  PC register write enable
- if_id_en  out  1  IF/ID register enable
- if_id_flush  out  1  IF/ID register loads a NOP
- id_ex_en  out  1  ID/EX register enable
- id_ex_flush  out  1  ID/EX register loads a NOP
- ex_mem_en  out  1  EX/MEM and MEM/WB register enable
- nop_EX  out  1  registered: the instruction now in EX is a bubble
- halted  out  1  core is parked
- stall_cycles  out  CNT_W  saturating count of cycles with pc_en=0 while not halted
- flush_count  out  CNT_W  saturating count of branch flushes

Behaviour:
- States: RUN, LOAD_STALL, HALT. A 3-bit down-counter cnt tracks the remaining bubbles.
- Reset (synchronous, rst=1): state=RUN, cnt=0, nop_EX=1, both counters=0. During rst, all enables=1 and all flushes=1, so the pipeline fills with NOPs. Reset mid-stall aborts the stall.
- Hazard qualifier: qual = !nop_EX. This gates branch_taken_EX, halt_EX and mem_read_EX; bubbles never trigger actions.
- Load-use condition: lu = qual & mem_read_EX & rd_EX!=0 & ((use_rs1_ID & rs1_ID==rd_EX) | (use_rs2_ID & rs2_ID==rd_EX)).
- Default outputs: all enables=1, all flushes=0.
- Priority, highest first, all combinational in the same cycle:
  1. Freeze: dmem_busy=1 in any state sets every enable=0 and every flush=0. State, cnt and nop_EX hold. stall_cycles increments if not HALT.
  2. HALT: pc_en=0, if_id_flush=1, id_ex_flush=1, halted=1. Leaves only via rst.
  3. RUN & qual & halt_EX: same outputs as HALT this cycle; next state HALT.
  4. RUN & qual & branch_taken_EX: if_id_flush=1, id_ex_flush=1, pc_en=1 so the PC loads the target. flush_count increments. Branch beats a simultaneous lu, because ID holds a wrong-path instruction.
  5. RUN & lu: pc_en=0, if_id_en=0, id_ex_flush=1, stall_cycles increments. If LOAD_STALL_CYCLES>1: cnt<=LOAD_STALL_CYCLES-1 and next state LOAD_STALL. Otherwise stay in RUN.
  6. LOAD_STALL: same outputs as case 5 and stall_cycles increments. cnt decrements. When cnt==1, next state is RUN. New lu is ignored because EX holds a bubble.
- nop_EX next value: when id_ex_en=1, it becomes id_ex_flush. When id_ex_en=0 (freeze), it holds.
- Counters saturate at all-ones and never wrap.
- Latency: hazard response in the same cycle, with zero registered delay on enables/flushes. The only registered outputs are nop_EX, halted and the counters.
- halted is a registered output: 1 exactly when state==HALT.

Decomposition:
- Shared package pipeline_pkg holds:
  - the state encoding (RUN=2'd0, LOAD_STALL=2'd1, HALT=2'd2);
  - the NOP encoding 32'h00000013;
  - REG_ZERO=5'd0.
- One sub-module, sat_counter (parameter W; inputs inc and clr; saturating), instantiated twice, once per performance counter.

Test Plan:
- Load-use: lw x5 in EX (rd_EX=5, mem_read_EX=1), ID reads rs1=5 with default parameters -> pc_en=0 and if_id_en=0 for exactly 2 cycles; id_ex_flush=1 in both; nop_EX=1 on the following 2 cycles; stall_cycles=2.
- rd_EX=0 load, or use_rs1_ID=0 with a matching register -> no stall; all enables stay 1.
- branch_taken_EX=1 together with a load-use match -> single cycle with if_id_flush=id_ex_flush=1 and pc_en=1; flush_count=1; next cycle nop_EX=1 and no stall.
- dmem_busy held 3 cycles in the middle of LOAD_STALL -> all enables=0 for 3 cycles; cnt is preserved; the stall then finishes its remaining cycle; stall_cycles increments by 3+remaining.
- halt_EX=1 -> halted=1 from the next cycle; pc_en stays 0 indefinitely. A later branch_taken_EX is ignored. rst=1 returns to RUN with nop_EX=1 and both counters=0.
- Force stall_cycles to all-ones via a CNT_W=4 build and apply 20 stall cycles -> counter reads 4'hF and holds there.
